// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC engine: FSM encodings, common
// generator polynomials and the bit-counter width helper.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } crc_state_e;

    // Generator polynomials without the implicit x^CRC_W term.
    localparam logic [4:0]  POLY_CRC5_USB    = 5'h05;
    localparam logic [7:0]  POLY_CRC8_ATM    = 8'h07;
    localparam logic [15:0] POLY_CRC16_CCITT = 16'h1021;
    localparam logic [31:0] POLY_CRC32       = 32'h04C11DB7;

    // Width of a counter that indexes bits 0..data_w-1 of a word.
    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// One bit step of a Galois CRC register: shift left, fold in the
// polynomial when the incoming bit differs from the outgoing MSB.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int               CRC_W = 5,
    parameter logic [CRC_W-1:0] POLY  = 5'h05
) (
    input  logic [CRC_W-1:0] r_in,
    input  logic             d,
    output logic [CRC_W-1:0] r_out
);

    logic fb_s;

    // Feedback bit and next register value
    always_comb begin
        fb_s = d ^ r_in[CRC_W-1];
        if (fb_s) begin
            r_out = {r_in[CRC_W-2:0], 1'b0} ^ POLY;
        end else begin
            r_out = {r_in[CRC_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine: accepts DATA_W-bit words over valid/ready, folds
// them one bit per cycle into a CRC_W-bit LFSR and emits one result per frame.
module crc_serial_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W     = 5,
    parameter int               DATA_W    = 4,
    parameter logic [CRC_W-1:0] POLY      = 5'h05,
    parameter logic [CRC_W-1:0] INIT      = 5'h00,
    parameter logic [CRC_W-1:0] XOR_OUT   = 5'h00,
    parameter int               LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              busy,
    output logic              crc_valid,
    output logic [CRC_W-1:0]  crc_out
);

    localparam int               CNT_W    = bit_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    crc_state_e        state_r;
    crc_state_e        next_state_s;
    logic [DATA_W-1:0] shift_r;
    logic              last_r;
    logic [CRC_W-1:0]  crc_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic              busy_r;
    logic              crc_valid_r;
    logic [CRC_W-1:0]  crc_out_r;
    logic              in_ready_r;

    logic              xfer_s;
    logic              load_s;
    logic              shift_en_s;
    logic              done_s;
    logic              last_bit_s;
    logic              data_bit_s;
    logic [CRC_W-1:0]  crc_step_s;

    assign xfer_s     = in_valid & in_ready_r;
    assign last_bit_s = (bit_cnt_r == LAST_BIT);

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .r_in  (crc_r),
        .d     (data_bit_s),
        .r_out (crc_step_s)
    );

    // Select the bit that leaves the word shift register this cycle
    always_comb begin
        if (LSB_FIRST != 0) begin
            data_bit_s = shift_r[0];
        end else begin
            data_bit_s = shift_r[DATA_W-1];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    next_state_s = ST_SHIFT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!last_bit_s) begin
                    next_state_s = ST_SHIFT;
                end else if (last_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode: datapath enables per state
    always_comb begin
        load_s     = 1'b0;
        shift_en_s = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE:  load_s     = xfer_s;
            ST_SHIFT: shift_en_s = 1'b1;
            ST_DONE:  done_s     = 1'b1;
            default: begin
                load_s     = 1'b0;
                shift_en_s = 1'b0;
                done_s     = 1'b0;
            end
        endcase
    end

    // Datapath: word capture, bit shifting, CRC accumulation and result
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r     <= {DATA_W{1'b0}};
            last_r      <= 1'b0;
            crc_r       <= INIT;
            bit_cnt_r   <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            crc_valid_r <= 1'b0;
            crc_out_r   <= {CRC_W{1'b0}};
            in_ready_r  <= 1'b1;
        end else begin
            crc_valid_r <= done_s;
            in_ready_r  <= (next_state_s == ST_IDLE);
            if (load_s) begin
                shift_r   <= in_data;
                last_r    <= in_last;
                bit_cnt_r <= {CNT_W{1'b0}};
                busy_r    <= 1'b1;
                // A word arriving while no frame is open starts a new frame.
                if (!busy_r) begin
                    crc_r <= INIT;
                end else begin
                    crc_r <= crc_r;
                end
            end else if (shift_en_s) begin
                crc_r <= crc_step_s;
                if (LSB_FIRST != 0) begin
                    shift_r <= shift_r >> 1;
                end else begin
                    shift_r <= shift_r << 1;
                end
                // Counter parks at zero after the last bit instead of wrapping.
                if (last_bit_s) begin
                    bit_cnt_r <= {CNT_W{1'b0}};
                end else begin
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                end
            end else if (done_s) begin
                crc_out_r <= crc_r ^ XOR_OUT;
                busy_r    <= 1'b0;
            end else begin
                crc_r <= crc_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign crc_valid = crc_valid_r;
    assign crc_out   = crc_out_r;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Bench for crc_serial_engine: directed cases on the default 5/4 engine,
// standard CRC8/CRC16 check values, and random frames with backpressure
// compared against a message-level reference CRC.
module tb_crc_serial_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    // Channel A: default 5-bit CRC, 4-bit words, LSB-first
    logic       a_valid, a_last, a_ready, a_busy, a_cval;
    logic [3:0] a_data;
    logic [4:0] a_crc;

    // Channel B: three 8-bit-word engines sharing one input stream
    logic        b_valid, b_last;
    logic [7:0]  b_data;
    logic        b_ready8, b_busy8, b_cval8;
    logic [7:0]  b_crc8;
    logic        b_ready16, b_busy16, b_cval16;
    logic [15:0] b_crc16;
    logic        b_readyx, b_busyx, b_cvalx;
    logic [11:0] b_crcx;

    int          a_pulses = 0;
    logic [63:0] a_res_q[$];
    logic [63:0] b_res8_q[$];
    logic [63:0] b_res16_q[$];
    logic [63:0] b_resx_q[$];
    int          msg_q[$];

    crc_serial_engine #(.CRC_W(5), .DATA_W(4), .POLY(5'h05), .INIT(5'h00),
                        .XOR_OUT(5'h00), .LSB_FIRST(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .in_last(a_last), .busy(a_busy),
        .crc_valid(a_cval), .crc_out(a_crc));

    crc_serial_engine #(.CRC_W(8), .DATA_W(8), .POLY(8'h07), .INIT(8'h00),
                        .XOR_OUT(8'h00), .LSB_FIRST(0)) dut_crc8 (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready8),
        .in_data(b_data), .in_last(b_last), .busy(b_busy8),
        .crc_valid(b_cval8), .crc_out(b_crc8));

    crc_serial_engine #(.CRC_W(16), .DATA_W(8), .POLY(16'h1021), .INIT(16'hFFFF),
                        .XOR_OUT(16'h0000), .LSB_FIRST(0)) dut_crc16 (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready16),
        .in_data(b_data), .in_last(b_last), .busy(b_busy16),
        .crc_valid(b_cval16), .crc_out(b_crc16));

    crc_serial_engine #(.CRC_W(12), .DATA_W(8), .POLY(12'h80F), .INIT(12'hABC),
                        .XOR_OUT(12'hFFF), .LSB_FIRST(1)) dut_crcx (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_readyx),
        .in_data(b_data), .in_last(b_last), .busy(b_busyx),
        .crc_valid(b_cvalx), .crc_out(b_crcx));

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC of the whole message in msg_q, bit by bit in feed order.
    function automatic logic [63:0] crc_model(input int w, input logic [63:0] poly,
                                              input logic [63:0] init, input logic [63:0] xorout,
                                              input int dw, input bit lsb);
        logic [63:0] r;
        logic [63:0] mask;
        logic [63:0] word;
        bit          b;
        bit          top;
        mask = (64'd1 << w) - 64'd1;
        r    = init & mask;
        foreach (msg_q[k]) begin
            word = 64'(msg_q[k]);
            for (int i = 0; i < dw; i++) begin
                b   = lsb ? word[i] : word[dw-1-i];
                top = r[w-1];
                r   = (r << 1) & mask;
                if (top ^ b) r = r ^ poly;
            end
        end
        return (r ^ xorout) & mask;
    endfunction

    // Result capture on each crc_valid pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (a_cval) begin
            a_pulses <= a_pulses + 1;
            a_res_q.push_back(64'(a_crc));
        end
        if (b_cval8)  b_res8_q.push_back(64'(b_crc8));
        if (b_cval16) b_res16_q.push_back(64'(b_crc16));
        if (b_cvalx)  b_resx_q.push_back(64'(b_crcx));
    end

    // Present a word on channel A and return at the negedge after its transfer edge.
    task automatic send_a(input logic [3:0] word, input logic last);
        int guard = 0;
        a_valid = 1'b1;
        a_last  = last;
        while (!a_ready && guard < 100) begin
            a_data = 4'($urandom_range(0, 15));
            @(negedge clk);
            guard++;
        end
        check_eq("a_ready_wait", 64'(a_ready), 64'd1);
        a_data = word;
        @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] word, input logic last);
        int guard = 0;
        b_valid = 1'b1;
        b_last  = last;
        while (!b_ready8 && guard < 100) begin
            b_data = 8'($urandom_range(0, 255));
            @(negedge clk);
            guard++;
        end
        check_eq("b_ready_wait", 64'(b_ready8), 64'd1);
        b_data = word;
        @(negedge clk);
    endtask

    task automatic check_b_results(input string tag, input logic [63:0] e8[$],
                                   input logic [63:0] e16[$], input logic [63:0] ex[$]);
        check_eq({tag, "_n8"},  64'(b_res8_q.size()),  64'(e8.size()));
        check_eq({tag, "_n16"}, 64'(b_res16_q.size()), 64'(e16.size()));
        check_eq({tag, "_nx"},  64'(b_resx_q.size()),  64'(ex.size()));
        for (int i = 0; i < e8.size() && i < b_res8_q.size(); i++)
            check_eq({tag, "_crc8"}, b_res8_q[i], e8[i]);
        for (int i = 0; i < e16.size() && i < b_res16_q.size(); i++)
            check_eq({tag, "_crc16"}, b_res16_q[i], e16[i]);
        for (int i = 0; i < ex.size() && i < b_resx_q.size(); i++)
            check_eq({tag, "_crcx"}, b_resx_q[i], ex[i]);
    endtask

    initial begin
        logic [7:0]  hist;
        logic [63:0] exp_q[$];
        logic [63:0] e8[$];
        logic [63:0] e16[$];
        logic [63:0] ex[$];
        int          low_cnt;
        int          pulses_before;
        int          nw;
        logic [3:0]  wa;
        logic [7:0]  wb;

        reset = 1'b1;
        a_valid = 1'b0; a_last = 1'b0; a_data = 4'h0;
        b_valid = 1'b0; b_last = 1'b0; b_data = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_a_ready", 64'(a_ready), 64'd1);
        check_eq("rst_a_busy",  64'(a_busy),  64'd0);
        check_eq("rst_a_cval",  64'(a_cval),  64'd0);
        check_eq("rst_a_crc",   64'(a_crc),   64'd0);
        check_eq("rst_b_ready", 64'({b_ready8, b_ready16, b_readyx}), 64'h7);
        check_eq("rst_b_busy",  64'({b_busy8, b_busy16, b_busyx}), 64'h0);
        check_eq("rst_b_cval",  64'({b_cval8, b_cval16, b_cvalx}), 64'h0);
        check_eq("rst_b_crc",   {28'd0, b_crc8, b_crc16, b_crcx}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single word 4'h1: pulse exactly at the sixth negedge after the accept edge
        a_res_q.delete();
        send_a(4'h1, 1'b1);
        a_valid = 1'b0;
        hist = 8'h00;
        hist[1] = a_cval;
        check_eq("a_busy_during", 64'(a_busy), 64'd1);
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            hist[k] = a_cval;
        end
        check_eq("single1_latency", 64'(hist), 64'h40);
        check_eq("single1_crc",  64'(a_crc),  64'h0D);
        check_eq("single1_busy", 64'(a_busy), 64'd0);

        // Single words 4'hF and 4'h0
        send_a(4'hF, 1'b1);
        a_valid = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("singleF_crc",  64'(a_crc),  64'h16);
        check_eq("singleF_busy", 64'(a_busy), 64'd0);
        send_a(4'h0, 1'b1);
        a_valid = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("single0_crc", 64'(a_crc), 64'h00);

        // Two-word frame with valid held high: 4 cycles of backpressure per word
        pulses_before = a_pulses;
        send_a(4'h1, 1'b0);
        low_cnt = 0;
        while (!a_ready && low_cnt < 20) begin
            low_cnt++;
            @(negedge clk);
        end
        check_eq("frame_ready_low", 64'(low_cnt), 64'd4);
        check_eq("frame_busy_mid",  64'(a_busy),  64'd1);
        send_a(4'h0, 1'b1);
        a_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("frame_pulses", 64'(a_pulses - pulses_before), 64'd1);
        check_eq("frame_crc",    64'(a_crc), 64'h0E);

        // Back-to-back single-word frames: INIT reload between frames
        a_res_q.delete();
        send_a(4'h1, 1'b1);
        send_a(4'hF, 1'b1);
        a_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("b2b_count", 64'(a_res_q.size()), 64'd2);
        if (a_res_q.size() == 2) begin
            check_eq("b2b_first",  a_res_q[0], 64'h0D);
            check_eq("b2b_second", a_res_q[1], 64'h16);
        end

        // Reset in the middle of shifting the second word aborts the frame
        pulses_before = a_pulses;
        send_a(4'h1, 1'b0);
        send_a(4'h3, 1'b1);
        a_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_ready", 64'(a_ready), 64'd1);
        check_eq("abort_crc",   64'(a_crc),   64'd0);
        check_eq("abort_busy",  64'(a_busy),  64'd0);
        repeat (12) @(negedge clk);
        check_eq("abort_no_pulse", 64'(a_pulses - pulses_before), 64'd0);
        send_a(4'h1, 1'b1);
        a_valid = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("after_abort_crc", 64'(a_crc), 64'h0D);

        // Random frames with gaps on channel A
        a_res_q.delete();
        exp_q.delete();
        for (int f = 0; f < 25; f++) begin
            msg_q.delete();
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                wa = 4'($urandom_range(0, 15));
                msg_q.push_back(int'(wa));
                if ($urandom_range(0, 1) == 1) begin
                    a_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
                send_a(wa, (k == nw - 1));
            end
            exp_q.push_back(crc_model(5, 64'h05, 64'h00, 64'h00, 4, 1'b1));
        end
        a_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("rand_a_count", 64'(a_res_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < a_res_q.size(); i++)
            check_eq("rand_a_crc", a_res_q[i], exp_q[i]);

        // Standard check string "123456789" on the 8-bit engines
        b_res8_q.delete(); b_res16_q.delete(); b_resx_q.delete();
        msg_q.delete();
        for (int k = 0; k < 9; k++) begin
            msg_q.push_back(32'h31 + k);
            send_b(8'(32'h31 + k), (k == 8));
        end
        b_valid = 1'b0;
        repeat (14) @(negedge clk);
        check_eq("std_busy", 64'({b_busy8, b_busy16, b_busyx}), 64'h0);
        e8  = '{64'hF4};
        e16 = '{64'h29B1};
        ex  = '{crc_model(12, 64'h80F, 64'hABC, 64'hFFF, 8, 1'b1)};
        check_b_results("std", e8, e16, ex);

        // Random frames with gaps on channel B
        b_res8_q.delete(); b_res16_q.delete(); b_resx_q.delete();
        e8.delete(); e16.delete(); ex.delete();
        for (int f = 0; f < 10; f++) begin
            msg_q.delete();
            nw = $urandom_range(1, 6);
            for (int k = 0; k < nw; k++) begin
                wb = 8'($urandom_range(0, 255));
                msg_q.push_back(int'(wb));
                if ($urandom_range(0, 2) == 0) begin
                    b_valid = 1'b0;
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                end
                send_b(wb, (k == nw - 1));
            end
            e8.push_back(crc_model(8, 64'h07, 64'h00, 64'h00, 8, 1'b0));
            e16.push_back(crc_model(16, 64'h1021, 64'hFFFF, 64'h0000, 8, 1'b0));
            ex.push_back(crc_model(12, 64'h80F, 64'hABC, 64'hFFF, 8, 1'b1));
        end
        b_valid = 1'b0;
        repeat (14) @(negedge clk);
        check_b_results("rand_b", e8, e16, ex);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
